// File: rtl/text_console.sv
// -----------------------------------------------------------------------------
// text_console
//   Character-stream writer for text mode RAM (tram). It accepts 8-bit
//   characters over a valid/ready handshake, tracks a cursor and writes glyph
//   words into tram. It also handles CR, LF, BS and FF, line wrap, and hardware
//   scroll. The screen is kept as a ring buffer addressed from scroll_offs.
//
// Ports
//   clk_sys      in   system clock
//   rst_sys_n    in   asynchronous reset, active low
//   in_valid     in   character available
//   in_ready     out  character accepted this cycle (high only when idle)
//   in_char      in   character code
//   fg_colr      in   foreground colour index, sampled with each accepted char
//   bg_colr      in   background colour index, sampled with each accepted char
//   tram_we      out  tram byte write enables (all-ones for one cycle, else 0)
//   tram_addr    out  tram word address
//   tram_din     out  tram write data {fg, bg, 3'b000, codepoint[20:0]}
//   scroll_offs  out  tram address of the top visible row
//   cursor_x     out  cursor column
//   cursor_y     out  cursor row, relative to the top visible row
//   busy         out  clearing the screen or a line (equals ~in_ready)
// -----------------------------------------------------------------------------
module text_console #(
  parameter int TRAM_ADDRW = 11,
  parameter int TRAM_HRES  = 84,
  parameter int TRAM_VRES  = 24,
  parameter int WORD       = 32,
  parameter int BYTE_CNT   = 4,
  parameter int CIDXW      = 4
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_char,
  input  logic [CIDXW-1:0]      fg_colr,
  input  logic [CIDXW-1:0]      bg_colr,
  output logic [BYTE_CNT-1:0]   tram_we,
  output logic [TRAM_ADDRW-1:0] tram_addr,
  output logic [WORD-1:0]       tram_din,
  output logic [TRAM_ADDRW-1:0] scroll_offs,
  output logic [7:0]            cursor_x,
  output logic [4:0]            cursor_y,
  output logic                  busy
);

  localparam logic [1:0] ST_CLR_ALL  = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_CLR_LINE = 2'd2;

  localparam int DEPTH = TRAM_HRES * TRAM_VRES;

  // Address sums carry one extra bit so the wrap compare sees the overflow.
  localparam logic [TRAM_ADDRW:0]   DEPTH_W       = (TRAM_ADDRW+1)'(DEPTH);
  localparam logic [TRAM_ADDRW:0]   HRES_W        = (TRAM_ADDRW+1)'(TRAM_HRES);
  localparam logic [TRAM_ADDRW-1:0] CNT_LAST_ALL  = TRAM_ADDRW'(DEPTH - 1);
  localparam logic [TRAM_ADDRW-1:0] CNT_LAST_LINE = TRAM_ADDRW'(TRAM_HRES - 1);
  localparam logic [7:0]            COL_LAST      = 8'(TRAM_HRES - 1);
  localparam logic [4:0]            ROW_LAST      = 5'(TRAM_VRES - 1);

  // Both operands of every sum are below DEPTH. That means one conditional
  // subtract is enough to bring the result back into range.
  function automatic logic [TRAM_ADDRW-1:0] wrap_addr(input logic [TRAM_ADDRW:0] a);
    logic [TRAM_ADDRW:0] t;
    t = (a >= DEPTH_W) ? (a - DEPTH_W) : a;
    return t[TRAM_ADDRW-1:0];
  endfunction

  function automatic logic [WORD-1:0] glyph(input logic [CIDXW-1:0] fg,
                                            input logic [CIDXW-1:0] bg,
                                            input logic [7:0]       ch);
    return {fg, bg, 3'b000, 13'd0, ch};
  endfunction

  logic [1:0]            r_state;
  logic [TRAM_ADDRW-1:0] r_cnt;
  logic [BYTE_CNT-1:0]   r_we;
  logic [TRAM_ADDRW-1:0] r_addr;
  logic [WORD-1:0]       r_din;
  logic [TRAM_ADDRW-1:0] r_scroll;
  logic [7:0]            r_cx;
  logic [4:0]            r_cy;
  logic [CIDXW-1:0]      r_blank_fg;
  logic [CIDXW-1:0]      r_blank_bg;

  logic [TRAM_ADDRW:0]   w_row_offs;
  logic [TRAM_ADDRW-1:0] w_cur_addr;
  logic [TRAM_ADDRW-1:0] w_line_addr;
  logic [TRAM_ADDRW-1:0] w_scroll_next;
  logic [WORD-1:0]       w_blank;
  logic                  w_printable;
  logic                  w_last_row;

  assign w_row_offs    = (TRAM_ADDRW+1)'(r_cy) * HRES_W;
  assign w_cur_addr    = wrap_addr({1'b0, r_scroll} + w_row_offs + (TRAM_ADDRW+1)'(r_cx));
  assign w_line_addr   = wrap_addr({1'b0, r_scroll} + {1'b0, r_cnt});
  assign w_scroll_next = wrap_addr({1'b0, r_scroll} + HRES_W);
  assign w_blank       = glyph(r_blank_fg, r_blank_bg, 8'h20);
  assign w_printable   = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign w_last_row    = (r_cy == ROW_LAST);

  // Main controller. Each clear state issues one blank write per cycle from
  // r_cnt. IDLE decodes one accepted character per cycle. When a newline
  // happens on the bottom row, the cursor row stays put. The old top row is
  // then blanked so it can reappear as the new bottom row once scroll_offs
  // advances past it.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state    <= ST_CLR_ALL;
      r_cnt      <= '0;
      r_we       <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_scroll   <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_blank_fg <= '1;
      r_blank_bg <= '0;
    end else begin
      r_we <= '0;
      case (r_state)
        ST_CLR_ALL: begin
          r_we   <= '1;
          r_addr <= r_cnt;
          r_din  <= w_blank;
          if (r_cnt == CNT_LAST_ALL) begin
            r_cnt    <= '0;
            r_scroll <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_CLR_LINE: begin
          r_we   <= '1;
          r_addr <= w_line_addr;
          r_din  <= w_blank;
          if (r_cnt == CNT_LAST_LINE) begin
            r_cnt    <= '0;
            r_scroll <= w_scroll_next;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (in_valid) begin
            // Keep the colours so that a clear caused by this character
            // blanks with them.
            r_blank_fg <= fg_colr;
            r_blank_bg <= bg_colr;
            if (w_printable) begin
              r_we   <= '1;
              r_addr <= w_cur_addr;
              r_din  <= glyph(fg_colr, bg_colr, in_char);
              if (r_cx == COL_LAST) begin
                r_cx <= '0;
                if (w_last_row) begin
                  r_cnt   <= '0;
                  r_state <= ST_CLR_LINE;
                end else begin
                  r_cy <= r_cy + 5'd1;
                end
              end else begin
                r_cx <= r_cx + 8'd1;
              end
            end else begin
              case (in_char)
                8'h0A: begin
                  r_cx <= '0;
                  if (w_last_row) begin
                    r_cnt   <= '0;
                    r_state <= ST_CLR_LINE;
                  end else begin
                    r_cy <= r_cy + 5'd1;
                  end
                end
                8'h0D: r_cx <= '0;
                8'h08: begin
                  if (r_cx != 8'd0) r_cx <= r_cx - 8'd1;
                end
                8'h0C: begin
                  r_cnt   <= '0;
                  r_state <= ST_CLR_ALL;
                end
                default: ;
              endcase
            end
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= ST_CLR_ALL;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign busy        = ~in_ready;
  assign tram_we     = r_we;
  assign tram_addr   = r_addr;
  assign tram_din    = r_din;
  assign scroll_offs = r_scroll;
  assign cursor_x    = r_cx;
  assign cursor_y    = r_cy;

endmodule

// File: tb/tb_text_console.sv
// -----------------------------------------------------------------------------
// tb_text_console
//   Self-checking bench for text_console. A write monitor compares every tram
//   write, in order, against a queue of expected writes. That queue is filled
//   by a screen-level model that works in rows, columns and modulo arithmetic.
//   A vector table and hand-written sequences cover the fixed cases. A
//   randomized character stream follows them.
// -----------------------------------------------------------------------------
module tb_text_console;

  localparam int HRES  = 84;
  localparam int VRES  = 24;
  localparam int DEPTH = HRES * VRES;

  logic        clkSys;
  logic        rstSysN;
  logic        inValid;
  logic        inReady;
  logic [7:0]  inChar;
  logic [3:0]  fgColr;
  logic [3:0]  bgColr;
  logic [3:0]  tramWe;
  logic [10:0] tramAddr;
  logic [31:0] tramDin;
  logic [10:0] scrollOffs;
  logic [7:0]  cursorX;
  logic [4:0]  cursorY;
  logic        busy;

  text_console dut (
    .clk_sys    (clkSys),
    .rst_sys_n  (rstSysN),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_char    (inChar),
    .fg_colr    (fgColr),
    .bg_colr    (bgColr),
    .tram_we    (tramWe),
    .tram_addr  (tramAddr),
    .tram_din   (tramDin),
    .scroll_offs(scrollOffs),
    .cursor_x   (cursorX),
    .cursor_y   (cursorY),
    .busy       (busy)
  );

  // Free-running clock, period 10.
  initial clkSys = 1'b0;
  always #5 clkSys = ~clkSys;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  ch;
    logic [3:0]  fg;
    logic [3:0]  bg;
    bit          wr;
    logic [10:0] addr;
    logic [31:0] din;
    logic [7:0]  cx;
    logic [4:0]  cy;
  } vec_t;

  wr_t expQ[$];
  int  mScroll;
  int  mCx;
  int  mCy;
  int  nCompared;
  int  nMismatch;
  int  nWrites;

  // Every comparison in the bench goes through this task.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] glyphWord(input logic [3:0] fg, input logic [3:0] bg, input logic [7:0] c);
    return {fg, bg, 3'b000, 21'(c)};
  endfunction

  // Screen model: whole-screen blank and row-level scroll.
  task automatic modelFill(input logic [3:0] fg, input logic [3:0] bg);
    for (int i = 0; i < DEPTH; i++) expQ.push_back({11'(i), glyphWord(fg, bg, 8'h20)});
    mScroll = 0;
    mCx     = 0;
    mCy     = 0;
  endtask

  task automatic modelNewline(input logic [3:0] fg, input logic [3:0] bg);
    if (mCy < VRES - 1) begin
      mCy++;
    end else begin
      for (int i = 0; i < HRES; i++)
        expQ.push_back({11'((mScroll + i) % DEPTH), glyphWord(fg, bg, 8'h20)});
      mScroll = (mScroll + HRES) % DEPTH;
    end
  endtask

  task automatic modelChar(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg);
    if (c >= 8'h20 && c <= 8'h7E) begin
      expQ.push_back({11'((mScroll + mCy * HRES + mCx) % DEPTH), glyphWord(fg, bg, c)});
      mCx++;
      if (mCx == HRES) begin
        mCx = 0;
        modelNewline(fg, bg);
      end
    end else if (c == 8'h0A) begin
      mCx = 0;
      modelNewline(fg, bg);
    end else if (c == 8'h0D) begin
      mCx = 0;
    end else if (c == 8'h08) begin
      if (mCx > 0) mCx--;
    end else if (c == 8'h0C) begin
      modelFill(fg, bg);
    end
  endtask

  // Write monitor: each write pulse must match the oldest expected write.
  always @(negedge clkSys) begin
    if (rstSysN && tramWe != 4'h0) begin
      wr_t e;
      nWrites++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWriteAddr", 32'(tramAddr), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("writeEnable", 32'(tramWe), 32'hF);
        checkOutput("writeAddr", 32'(tramAddr), 32'(e.addr));
        checkOutput("writeData", tramDin, e.data);
      end
    end
  end

  // Sends one character. The task returns at the falling edge after the
  // accepting clock edge, which is where that character's write is visible.
  task automatic applyStimulus(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg);
    int w;
    @(negedge clkSys);
    w = 0;
    while (!inReady && w < 5000) begin
      @(negedge clkSys);
      w++;
    end
    if (!inReady) begin
      checkOutput("readyTimeout", 32'(inReady), 32'd1);
      return;
    end
    inValid = 1'b1;
    inChar  = c;
    fgColr  = fg;
    bgColr  = bg;
    modelChar(c, fg, bg);
    @(posedge clkSys);
    @(negedge clkSys);
    inValid = 1'b0;
  endtask

  task automatic waitIdle();
    int w;
    w = 0;
    while (!inReady && w < 5000) begin
      @(negedge clkSys);
      w++;
    end
    checkOutput("idleTimeout", 32'(inReady), 32'd1);
  endtask

  task automatic checkCursor(input string tag);
    checkOutput({tag, ".cursorX"}, 32'(cursorX), 32'(mCx));
    checkOutput({tag, ".cursorY"}, 32'(cursorY), 32'(mCy));
    checkOutput({tag, ".scroll"}, 32'(scrollOffs), 32'(mScroll));
  endtask

  // Reset, then follow the full-screen clear through to its end.
  task automatic doReset();
    int cnt;
    @(negedge clkSys);
    rstSysN = 1'b0;
    inValid = 1'b0;
    expQ.delete();
    modelFill(4'hF, 4'h0);
    repeat (2) @(negedge clkSys);
    nWrites = 0;
    rstSysN = 1'b1;
    cnt = 0;
    while (busy && cnt < 5000) begin
      @(negedge clkSys);
      cnt++;
    end
    #1;
    checkOutput("clrAllCycles", 32'(cnt), 32'(DEPTH));
    checkOutput("clrAllWrites", 32'(nWrites), 32'(DEPTH));
    checkOutput("clrAllDrained", 32'(expQ.size()), 32'd0);
    checkOutput("clrAllReady", 32'(inReady), 32'd1);
    checkCursor("afterClrAll");
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[16];
    int   cnt;
    logic [7:0] c;
    int   r;

    vecs[0]  = '{8'h41, 4'h2, 4'h1, 1'b1, 11'd0,  32'h2100_0041, 8'd1, 5'd0};
    vecs[1]  = '{8'h62, 4'h3, 4'h4, 1'b1, 11'd1,  32'h3400_0062, 8'd2, 5'd0};
    vecs[2]  = '{8'h0D, 4'h0, 4'h0, 1'b0, 11'd0,  32'h0,         8'd0, 5'd0};
    vecs[3]  = '{8'h08, 4'h0, 4'h0, 1'b0, 11'd0,  32'h0,         8'd0, 5'd0};
    vecs[4]  = '{8'h07, 4'h0, 4'h0, 1'b0, 11'd0,  32'h0,         8'd0, 5'd0};
    vecs[5]  = '{8'h7A, 4'hF, 4'h0, 1'b1, 11'd0,  32'hF000_007A, 8'd1, 5'd0};
    vecs[6]  = '{8'h0A, 4'h0, 4'h0, 1'b0, 11'd0,  32'h0,         8'd0, 5'd1};
    vecs[7]  = '{8'h7E, 4'h0, 4'hF, 1'b1, 11'd84, 32'h0F00_007E, 8'd1, 5'd1};
    vecs[8]  = '{8'h7F, 4'h1, 4'h1, 1'b0, 11'd0,  32'h0,         8'd1, 5'd1};
    vecs[9]  = '{8'h1F, 4'h1, 4'h1, 1'b0, 11'd0,  32'h0,         8'd1, 5'd1};
    vecs[10] = '{8'h20, 4'h5, 4'h6, 1'b1, 11'd85, 32'h5600_0020, 8'd2, 5'd1};
    vecs[11] = '{8'h08, 4'h0, 4'h0, 1'b0, 11'd0,  32'h0,         8'd1, 5'd1};
    vecs[12] = '{8'h21, 4'h1, 4'h2, 1'b1, 11'd85, 32'h1200_0021, 8'd2, 5'd1};
    vecs[13] = '{8'h80, 4'h0, 4'h0, 1'b0, 11'd0,  32'h0,         8'd2, 5'd1};
    vecs[14] = '{8'h0D, 4'h0, 4'h0, 1'b0, 11'd0,  32'h0,         8'd0, 5'd1};
    vecs[15] = '{8'h08, 4'h0, 4'h0, 1'b0, 11'd0,  32'h0,         8'd0, 5'd1};

    nCompared = 0;
    nMismatch = 0;
    nWrites   = 0;
    rstSysN   = 1'b0;
    inValid   = 1'b0;
    inChar    = 8'h00;
    fgColr    = 4'h0;
    bgColr    = 4'h0;
    mScroll   = 0;
    mCx       = 0;
    mCy       = 0;

    // Reset values, while reset is still held.
    #12;
    checkOutput("rstWe", 32'(tramWe), 32'd0);
    checkOutput("rstAddr", 32'(tramAddr), 32'd0);
    checkOutput("rstDin", tramDin, 32'd0);
    checkOutput("rstReady", 32'(inReady), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd1);

    doReset();

    // Vector table, starting from a freshly cleared screen.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].ch, vecs[i].fg, vecs[i].bg);
      checkOutput($sformatf("vec%0d.we", i), 32'(tramWe), vecs[i].wr ? 32'hF : 32'h0);
      if (vecs[i].wr) begin
        checkOutput($sformatf("vec%0d.addr", i), 32'(tramAddr), 32'(vecs[i].addr));
        checkOutput($sformatf("vec%0d.din", i), tramDin, vecs[i].din);
      end
      checkOutput($sformatf("vec%0d.cx", i), 32'(cursorX), 32'(vecs[i].cx));
      checkOutput($sformatf("vec%0d.cy", i), 32'(cursorY), 32'(vecs[i].cy));
      if (i == 0) begin
        @(negedge clkSys);
        checkOutput("wePulseWidth", 32'(tramWe), 32'd0);
      end
    end

    // CR at column 10 moves the cursor home without writing.
    for (int i = 0; i < 10; i++) applyStimulus(8'h30 + 8'(i), 4'h7, 4'h0);
    checkOutput("crSetupX", 32'(cursorX), 32'd10);
    applyStimulus(8'h0D, 4'h7, 4'h0);
    checkOutput("crNoWrite", 32'(tramWe), 32'd0);
    checkOutput("crCursorX", 32'(cursorX), 32'd0);

    // A full row of printable characters wraps to the next row.
    doReset();
    for (int i = 0; i < HRES; i++) applyStimulus(8'h61 + 8'(i % 26), 4'h2, 4'h1);
    checkOutput("rowLastAddr", 32'(tramAddr), 32'd83);
    checkOutput("rowWrapX", 32'(cursorX), 32'd0);
    checkOutput("rowWrapY", 32'(cursorY), 32'd1);
    applyStimulus(8'h5A, 4'h2, 4'h1);
    checkOutput("row85Addr", 32'(tramAddr), 32'd84);

    // An LF on the bottom row scrolls. 24 scrolls bring the offset back to 0.
    doReset();
    for (int i = 0; i < VRES - 1; i++) applyStimulus(8'h0A, 4'hF, 4'h0);
    checkOutput("bottomRowY", 32'(cursorY), 32'd23);
    applyStimulus(8'h0A, 4'hE, 4'h3);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clkSys);
    end
    #1;
    checkOutput("clrLineBusyCycles", 32'(cnt), 32'd84);
    checkOutput("scrollAfterLf", 32'(scrollOffs), 32'd84);
    checkOutput("cursorYAfterLf", 32'(cursorY), 32'd23);
    applyStimulus(8'h42, 4'h4, 4'h5);
    checkOutput("wrapWriteAddr", 32'(tramAddr), 32'd0);
    checkOutput("wrapWriteData", tramDin, 32'h4500_0042);
    for (int i = 0; i < VRES - 1; i++) begin
      applyStimulus(8'h0A, 4'hF, 4'h1);
      waitIdle();
    end
    checkOutput("scrollWrapZero", 32'(scrollOffs), 32'd0);

    // Reset in the middle of a line clear aborts it immediately.
    applyStimulus(8'h0A, 4'hF, 4'h0);
    repeat (40) @(negedge clkSys);
    rstSysN = 1'b0;
    #1;
    checkOutput("abortWe", 32'(tramWe), 32'd0);
    checkOutput("abortAddr", 32'(tramAddr), 32'd0);
    checkOutput("abortDin", tramDin, 32'd0);
    checkOutput("abortScroll", 32'(scrollOffs), 32'd0);
    checkOutput("abortCursorX", 32'(cursorX), 32'd0);
    checkOutput("abortCursorY", 32'(cursorY), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd1);
    doReset();

    // Randomized stream checked against the screen model.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      c = 8'($urandom_range(32, 126));
      else if (r < 80) c = 8'h0A;
      else if (r < 85) c = 8'h0D;
      else if (r < 90) c = 8'h08;
      else if (r < 99) c = 8'($urandom);
      else             c = 8'h0C;
      applyStimulus(c, 4'($urandom), 4'($urandom));
      waitIdle();
      checkCursor($sformatf("rand%0d", n));
    end

    repeat (3) @(negedge clkSys);
    checkOutput("finalDrained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
